// File: rtl/pipe_hazard_ctrl_if.sv
// Front-end pipeline control bus: hazard/redirect/fetch status in, stage control and debug out.
interface pipe_hazard_ctrl_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        ex_valid;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_redirect;
    logic        imem_busy;
    logic        pc_en;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        fetch_valid;
    logic [1:0]  state;
    logic [31:0] stall_cycles;
    logic        imem_timeout;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_valid, ex_mem_read, ex_rd, ex_redirect, imem_busy,
        input  pc_en, ifid_stall, ifid_flush, idex_bubble, fetch_valid,
               state, stall_cycles, imem_timeout
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_valid, ex_mem_read, ex_rd, ex_redirect, imem_busy,
        output pc_en, ifid_stall, ifid_flush, idex_bubble, fetch_valid,
               state, stall_cycles, imem_timeout
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline front-end controller: load-use stalls, post-redirect flush and IMEM wait parking,
// with a saturating stall counter and sticky fetch-timeout flag.
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input logic                clk,
    input logic                reset,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam int unsigned FLUSH_W = 4;
    localparam int unsigned WAIT_W  = 16;
    localparam int unsigned STALL_W = 32;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FLUSH     = 2'd1,
        IMEM_WAIT = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [FLUSH_W-1:0]   flush_q, flush_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic                 timeout_q, timeout_d;

    logic load_use;
    logic pc_en_c, ifid_stall_c, ifid_flush_c, idex_bubble_c, fetch_valid_c;
    logic run_ctl;

    assign load_use = bus.id_valid & bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                      ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                       (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

    // Next-state and control decode; priority is redirect, then load-use, then imem_busy.
    always_comb begin
        pc_en_c       = 1'b0;
        ifid_stall_c  = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        fetch_valid_c = 1'b0;
        run_ctl       = 1'b0;
        state_d       = state_q;
        flush_d       = flush_q;
        wait_d        = wait_q;
        timeout_d     = timeout_q;

        if (reset) begin
            state_d   = RUN;
            flush_d   = '0;
            wait_d    = '0;
            timeout_d = 1'b0;
        end else if (bus.ex_redirect) begin
            pc_en_c       = 1'b1;
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
            flush_d       = FLUSH_W'(FLUSH_CYCLES - 1);
            state_d       = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
            wait_d        = '0;
        end else begin
            case (state_q)
                FLUSH: begin
                    ifid_flush_c = 1'b1;
                    pc_en_c      = ~bus.imem_busy;
                    if (!bus.imem_busy) begin
                        flush_d = (flush_q == '0) ? '0 : flush_q - FLUSH_W'(1);
                        if (flush_q <= FLUSH_W'(1)) state_d = RUN;
                    end
                end
                IMEM_WAIT: begin
                    if (bus.imem_busy) begin
                        idex_bubble_c = load_use;
                        wait_d        = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);
                    end else begin
                        state_d = RUN;
                        wait_d  = '0;
                        run_ctl = 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                    run_ctl = 1'b1;
                end
            endcase

            if (run_ctl) begin
                if (load_use) begin
                    ifid_stall_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                end else if (bus.imem_busy) begin
                    state_d = IMEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end else begin
                    pc_en_c       = 1'b1;
                    fetch_valid_c = 1'b1;
                end
            end

            // Timeout is judged on the count held during the wait cycle itself.
            if (state_q == IMEM_WAIT && 32'(wait_q) >= WAIT_TIMEOUT) timeout_d = 1'b1;
        end

        if (reset)
            stall_d = '0;
        else if (!pc_en_c && stall_q != '1)
            stall_d = stall_q + STALL_W'(1);
        else
            stall_d = stall_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            flush_q   <= '0;
            wait_q    <= '0;
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            wait_q    <= wait_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.pc_en        = pc_en_c;
    assign bus.ifid_stall   = ifid_stall_c;
    assign bus.ifid_flush   = ifid_flush_c;
    assign bus.idex_bubble  = idex_bubble_c;
    assign bus.fetch_valid  = fetch_valid_c;
    assign bus.state        = state_q;
    assign bus.stall_cycles = stall_q;
    assign bus.imem_timeout = timeout_q;
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Front-end pipeline controller for the 5-stage core. It sequences the PC register, the IF/ID register and the ID/EX bubble insertion by:
- detecting load-use hazards between ID and EX;
- running a multi-cycle flush after an EX-stage redirect;
- parking fetch while instruction memory is busy.

It also keeps a saturating stall-cycle counter and a sticky fetch-timeout flag for debug.

Parameters:
FLUSH_CYCLES, 2, cycles fetch_valid stays low after a redirect, counting the redirect cycle itself; legal range 1..15.
WAIT_TIMEOUT, 255, consecutive IMEM_WAIT cycles before imem_timeout sets; legal range 1..65535.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
id_valid  in  1  IF/ID holds a valid instruction.
id_rs1  in  5  source register 1 of the ID instruction.
id_rs2  in  5  source register 2 of the ID instruction.
id_uses_rs1  in  1  ID instruction reads rs1.
id_uses_rs2  in  1  ID instruction reads rs2.
ex_valid  in  1  ID/EX holds a valid instruction.
ex_mem_read  in  1  EX instruction is a load.
ex_rd  in  5  destination register of the EX instruction.
ex_redirect  in  1  taken branch or jump resolved in EX this cycle.
imem_busy  in  1  instruction memory cannot return data this cycle.
pc_en  out  1  PC register update enable.
ifid_stall  out  1  IF/ID register holds its contents.
ifid_flush  out  1  IF/ID register clears its valid bit.
idex_bubble  out  1  ID/EX register loads a bubble (valid=0).
fetch_valid  out  1  drives is_valid_in of IF/ID.
state  out  2  current FSM state: RUN=0, FLUSH=1, IMEM_WAIT=2.
stall_cycles  out  32  saturating count of cycles with pc_en=0 while out of reset.
imem_timeout  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Clocking and reset:
  - Single clock, clk. Reset is synchronous and active-high on reset.
  - Reset values: state=RUN, flush counter=0, wait counter=0, stall_cycles=0, imem_timeout=0.
  - While reset=1, every control output is forced to 0 (pc_en, ifid_stall, ifid_flush, idex_bubble, fetch_valid).
- Load-use hazard (combinational): load_use = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Control outputs are combinational from state and current inputs. Priority is ex_redirect > load_use > imem_busy > normal.
- Redirect cycle (ex_redirect=1, any state):
  - pc_en=1, ifid_flush=1, idex_bubble=1, fetch_valid=0, ifid_stall=0.
  - Flush counter loads FLUSH_CYCLES-1.
  - Next state is RUN if FLUSH_CYCLES==1, otherwise FLUSH.
  - The wait counter clears.
  - A redirect in FLUSH restarts the count.
- RUN with load_use: pc_en=0, ifid_stall=1, idex_bubble=1, fetch_valid=0. State stays RUN; the hazard lasts exactly one cycle because EX then holds the bubble.
- RUN with imem_busy (and no load_use): pc_en=0, fetch_valid=0; next state IMEM_WAIT; the wait counter loads 1.
- RUN, normal: pc_en=1, fetch_valid=1, all other control outputs 0.
- FLUSH:
  - fetch_valid=0, ifid_flush=1, pc_en=!imem_busy.
  - The counter decrements only when imem_busy=0.
  - On the decrement that makes the counter 0, next state is RUN.
- IMEM_WAIT:
  - pc_en=0, fetch_valid=0; idex_bubble=load_use.
  - The wait counter increments with 16-bit saturation.
  - When the counter reaches WAIT_TIMEOUT, imem_timeout sets and stays set.
  - When imem_busy=0, next state is RUN (outputs follow the RUN rules in that cycle) and the wait counter clears.
- stall_cycles increments every cycle in which pc_en=0 and reset=0, and saturates at 0xFFFFFFFF (no wrap).
- Reset asserted mid-FLUSH or mid-IMEM_WAIT returns the block to RUN next cycle with all counters cleared.

Test Plan:
- Reset held 3 cycles, then released with all inputs 0 → during reset all control outputs are 0 and state=0; after release pc_en=1, fetch_valid=1, stall_cycles=0.
- id_valid=1, id_rs1=5, id_uses_rs1=1, ex_valid=1, ex_mem_read=1, ex_rd=5 for one cycle → pc_en=0, ifid_stall=1, idex_bubble=1, stall_cycles=1. Repeat with ex_rd=0 → no stall.
- ex_redirect pulsed 1 cycle with FLUSH_CYCLES=2 → cycle 0: ifid_flush=1, idex_bubble=1, pc_en=1; cycle 1: state=1, fetch_valid=0; cycle 2: state=0, fetch_valid=1.
- ex_redirect and load_use in the same cycle → redirect wins: pc_en=1, ifid_stall=0, ifid_flush=1.
- imem_busy held 4 cycles in RUN → state=2 for cycles 1-4, pc_en=0 in cycles 0-3, stall_cycles=4; RUN resumes when imem_busy falls.
- WAIT_TIMEOUT=3, imem_busy held 10 cycles → imem_timeout rises after the third IMEM_WAIT cycle and stays 1 after imem_busy drops; reset clears it.
